io_switch_debouncer: RTL and testbench



---
 rtl/io_pkg.sv | 14 +
 rtl/io_debounce_chan.sv | 79 +++++++
 rtl/io_switch_debouncer.sv | 38 +++
 tb/tb_io_switch_debouncer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the switch-conditioning path feeding DMemory_IO.
// Holds the debouncer FSM encoding and the debounce-length constants.
package io_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_e;

  // 1 ms at 50 MHz on the board; the short value keeps simulations quick.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int DEBOUNCE_CYCLES_SIM     = 4;

endpackage

// File: rtl/io_debounce_chan.sv
// One switch channel: 2-flop synchroniser, counter-based debouncer,
// registered rise/fall pulses and a CPU-clearable sticky change flag.
module io_debounce_chan
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int   CNT_W           = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  input  logic changed_clr,
  output logic sw_stable,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  deb_state_e       state;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; the synchroniser depends on this.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q1    <= RESET_VAL;
      sync_q2    <= RESET_VAL;
      sw_stable  <= RESET_VAL;
      cnt        <= '0;
      state      <= ST_STABLE;
      sw_rise    <= 1'b0;
      sw_fall    <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      // The later set in the accept branch overrides this clear.
      if (changed_clr) sw_changed <= 1'b0;

      case (state)
        ST_STABLE: begin
          if (sync_q2 != sw_stable) begin
            cnt   <= CNT_W'(1);
            state <= ST_COUNTING;
          end else begin
            cnt <= '0;
          end
        end
        ST_COUNTING: begin
          if (sync_q2 == sw_stable) begin
            cnt   <= '0;
            state <= ST_STABLE;
          end else if (cnt == CNT_LAST) begin
            sw_stable  <= sync_q2;
            sw_rise    <= sync_q2;
            sw_fall    <= ~sync_q2;
            sw_changed <= 1'b1;
            cnt        <= '0;
            state      <= ST_STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_switch_debouncer.sv
// Conditions the raw board switch pins ahead of DMemory_IO's io_sw0/io_sw1;
// each channel is an independent io_debounce_chan instance.
module io_switch_debouncer
  import io_pkg::*;
#(
  parameter int   NUM_SW          = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int   CNT_W           = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic [NUM_SW-1:0] changed_clr,
  output logic [NUM_SW-1:0] sw_stable,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic [NUM_SW-1:0] sw_changed
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    io_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RESET_VAL      (RESET_VAL)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .sw_raw     (sw_raw[i]),
      .changed_clr(changed_clr[i]),
      .sw_stable  (sw_stable[i]),
      .sw_rise    (sw_rise[i]),
      .sw_fall    (sw_fall[i]),
      .sw_changed (sw_changed[i])
    );
  end

endmodule

// File: tb/tb_io_switch_debouncer.sv
// Directed plus randomized bench for io_switch_debouncer with a short
// debounce length, compared every cycle against a behavioural model.
module tb_io_switch_debouncer;
  import io_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic       clock;
  logic       reset;
  logic [1:0] sw_raw;
  logic [1:0] changed_clr;
  logic [1:0] sw_stable, sw_rise, sw_fall, sw_changed;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: delayed pin samples, accepted level, outputs, and the
  // number of consecutive synchronised samples disagreeing with the level.
  logic [1:0] m_q1, m_q2, m_stable, m_rise, m_fall, m_changed;
  int         run_len [2];

  io_switch_debouncer #(
    .NUM_SW         (2),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16),
    .RESET_VAL      (1'b0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .changed_clr(changed_clr),
    .sw_stable  (sw_stable),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // A level is accepted once the synchronised input has shown it D times in
  // a row; any agreeing sample in between restarts the tally.
  task automatic model_step();
    logic [1:0] seen;
    if (!reset) begin
      m_q1 = '0; m_q2 = '0; m_stable = '0;
      m_rise = '0; m_fall = '0; m_changed = '0;
      run_len = '{0, 0};
    end else begin
      seen   = m_q2;
      m_q2   = m_q1;
      m_q1   = sw_raw;
      m_rise = '0;
      m_fall = '0;
      m_changed = m_changed & ~changed_clr;
      for (int c = 0; c < 2; c++) begin
        if (seen[c] != m_stable[c]) begin
          run_len[c]++;
          if (run_len[c] == D) begin
            m_stable[c]  = seen[c];
            m_rise[c]    = seen[c];
            m_fall[c]    = ~seen[c];
            m_changed[c] = 1'b1;
            run_len[c]   = 0;
          end
        end else begin
          run_len[c] = 0;
        end
      end
    end
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check("model_stable",  {1'b0, sw_stable},  {1'b0, m_stable});
    check("model_rise",    {1'b0, sw_rise},    {1'b0, m_rise});
    check("model_fall",    {1'b0, sw_fall},    {1'b0, m_fall});
    check("model_changed", {1'b0, sw_changed}, {1'b0, m_changed});
  endtask

  initial begin
    int hold [2];
    hold = '{0, 0};
    m_q1 = '0; m_q2 = '0; m_stable = '0;
    m_rise = '0; m_fall = '0; m_changed = '0;
    run_len = '{0, 0};

    // Reset held with both switches on, then release.
    reset = 1'b0; sw_raw = 2'b11; changed_clr = 2'b00;
    repeat (3) cyc();
    check("rst_stable",  {1'b0, sw_stable},  3'b000);
    check("rst_pulses",  {1'b0, sw_rise | sw_fall}, 3'b000);
    check("rst_changed", {1'b0, sw_changed}, 3'b000);
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 5) check("rel_early", {1'b0, sw_stable}, 3'b000);
      if (k == 6) begin
        check("rel_stable", {1'b0, sw_stable}, 3'b011);
        check("rel_rise",   {1'b0, sw_rise},   3'b011);
      end
    end
    cyc();
    check("rel_rise_end", {1'b0, sw_rise},    3'b000);
    check("rel_changed",  {1'b0, sw_changed}, 3'b011);

    // Return both channels to 0 and clear the flags.
    sw_raw = 2'b00;
    repeat (8) cyc();
    changed_clr = 2'b11; cyc(); changed_clr = 2'b00;
    cyc();
    check("idle_changed", {1'b0, sw_changed}, 3'b000);

    // Clean rising edge on channel 0.
    sw_raw = 2'b01;
    for (int k = 0; k <= 6; k++) begin
      cyc();
      if (k == 4) check("clean_early", {1'b0, sw_stable}, 3'b000);
      if (k == 5) begin
        check("clean_stable", {1'b0, sw_stable}, 3'b001);
        check("clean_rise",   {1'b0, sw_rise},   3'b001);
      end
      if (k == 6) check("clean_rise_end", {1'b0, sw_rise}, 3'b000);
    end

    // Bouncing channel 1: three high samples never reach the limit.
    repeat (5) begin
      sw_raw[1] = 1'b1;
      repeat (3) begin
        cyc();
        check("bounce_ch1", {sw_stable[1], sw_rise[1], sw_changed[1]}, 3'b000);
      end
      sw_raw[1] = 1'b0;
      repeat (2) begin
        cyc();
        check("bounce_ch1", {sw_stable[1], sw_rise[1], sw_changed[1]}, 3'b000);
      end
    end
    repeat (4) begin
      cyc();
      check("bounce_tail", {sw_stable[1], sw_rise[1], sw_changed[1]}, 3'b000);
    end

    // Falling edge with a clear strobe landing on the same edge as the set.
    changed_clr = 2'b01; cyc(); changed_clr = 2'b00;
    check("pre_fall_clr", {1'b0, sw_changed}, 3'b000);
    sw_raw[0] = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) changed_clr = 2'b01;
      cyc();
      if (k == 5) begin
        check("coll_fall",    {1'b0, sw_fall},    3'b001);
        check("coll_changed", {1'b0, sw_changed}, 3'b001);
      end
    end
    changed_clr = 2'b00;
    cyc();
    check("coll_sticky", {1'b0, sw_changed}, 3'b001);
    changed_clr = 2'b01; cyc(); changed_clr = 2'b00;
    check("late_clr", {1'b0, sw_changed}, 3'b000);

    // Reset while channel 0 is counting (counter at 2).
    sw_raw = 2'b01;
    repeat (4) cyc();
    reset = 1'b0; cyc(); reset = 1'b1;
    check("mid_rst", {1'b0, sw_stable}, 3'b000);
    for (int k = 0; k <= 5; k++) begin
      cyc();
      if (k == 4) check("mid_early",  {1'b0, sw_stable}, 3'b000);
      if (k == 5) check("mid_stable", {1'b0, sw_stable}, 3'b001);
    end

    // Independence: channel 0 rises while channel 1 falls.
    sw_raw = 2'b10;
    repeat (8) cyc();
    changed_clr = 2'b11; cyc(); changed_clr = 2'b00;
    check("ind_setup", {1'b0, sw_stable}, 3'b010);
    sw_raw = 2'b01;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      if (k == 4) check("ind_early", {1'b0, sw_rise | sw_fall}, 3'b000);
      if (k == 5) begin
        check("ind_rise",   {1'b0, sw_rise},   3'b001);
        check("ind_fall",   {1'b0, sw_fall},   3'b010);
        check("ind_stable", {1'b0, sw_stable}, 3'b001);
      end
    end

    // Randomized pin activity with occasional clears and resets.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          sw_raw[c] = 1'($urandom_range(0, 1));
          hold[c]   = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      changed_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      reset       = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
